issue_queue: RTL and testbench

//  Buffered, parametrised issue stage between instruction fetch and the RS/SLB backends.

---
 rtl/issue_queue_pkg.sv | 46 ++++
 rtl/issue_queue_if.sv | 39 +++
 rtl/issue_queue_decode.sv | 56 +++++
 rtl/issue_queue.sv | 144 ++++++++++++++
 tb/tb_issue_queue.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
// Shared opcode, instruction-type and head codes for the issue queue, plus the queue entry layout.
package issue_queue_pkg;

  localparam int OP_WIDTH = 10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    TYPE_NONE = 3'd0,
    TYPE_R    = 3'd1,
    TYPE_I    = 3'd2,
    TYPE_S    = 3'd3,
    TYPE_B    = 3'd4,
    TYPE_U    = 3'd5,
    TYPE_J    = 3'd6
  } instr_type_e;

  localparam logic [2:0] HEAD_NONE   = 3'd0;
  localparam logic [2:0] HEAD_BASE   = 3'd1;
  localparam logic [2:0] HEAD_ALT    = 3'd2;
  localparam logic [2:0] HEAD_JALR   = 3'd3;
  localparam logic [2:0] HEAD_FENCE  = 3'd4;
  localparam logic [2:0] HEAD_SYSTEM = 3'd5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } iq_entry_t;

  function automatic logic [OP_WIDTH-1:0] make_op(input logic [2:0] itype,
                                                  input logic [2:0] head,
                                                  input logic [3:0] sub);
    return {itype, head, sub};
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side push port and RS/SLB dispatch port of the issue queue.
interface issue_queue_if #(
  parameter int ADDR_WIDTH     = 3,
  parameter int REG_ADDR_WIDTH = 5
);
  import issue_queue_pkg::*;

  logic                      rdy_in;
  logic                      flush_in;
  logic                      in_valid;
  logic [31:0]               in_instr;
  logic [31:0]               in_npc;
  logic                      in_ready;
  logic                      rs_ready_in;
  logic                      slb_ready_in;
  logic                      rs_valid;
  logic                      slb_valid;
  logic [OP_WIDTH-1:0]       out_op;
  logic [REG_ADDR_WIDTH-1:0] out_rs1;
  logic [REG_ADDR_WIDTH-1:0] out_rs2;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic [31:0]               out_imm;
  logic [31:0]               out_npc;
  logic                      illegal_out;
  logic [ADDR_WIDTH:0]       count_out;

  modport master (
    output rdy_in, flush_in, in_valid, in_instr, in_npc, rs_ready_in, slb_ready_in,
    input  in_ready, rs_valid, slb_valid, out_op, out_rs1, out_rs2, out_rd,
           out_imm, out_npc, illegal_out, count_out
  );

  modport slave (
    input  rdy_in, flush_in, in_valid, in_instr, in_npc, rs_ready_in, slb_ready_in,
    output in_ready, rs_valid, slb_valid, out_op, out_rs1, out_rs2, out_rd,
           out_imm, out_npc, illegal_out, count_out
  );

endinterface

// File: rtl/issue_queue_decode.sv
// Combinational RV32I decoder for the queue head: op, register indices, immediate, target and legality.
module issue_queue_decode import issue_queue_pkg::*; #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [31:0]               instr,
  output logic [OP_WIDTH-1:0]       op,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [31:0]               imm,
  output logic                      to_slb,
  output logic                      illegal
);

  instr_type_e itype;
  logic [2:0]  head;

  always_comb begin
    itype  = TYPE_NONE;
    head   = HEAD_NONE;
    to_slb = 1'b0;
    case (instr[6:0])
      OPC_STORE:  begin itype = TYPE_S; head = HEAD_BASE;   to_slb = 1'b1; end
      OPC_LOAD:   begin itype = TYPE_I; head = HEAD_BASE;   to_slb = 1'b1; end
      OPC_OP:     begin itype = TYPE_R; head = HEAD_BASE;   end
      OPC_OP_IMM: begin itype = TYPE_I; head = HEAD_ALT;    end
      OPC_JALR:   begin itype = TYPE_I; head = HEAD_JALR;   end
      OPC_FENCE:  begin itype = TYPE_I; head = HEAD_FENCE;  end
      OPC_SYSTEM: begin itype = TYPE_I; head = HEAD_SYSTEM; end
      OPC_LUI:    begin itype = TYPE_U; head = HEAD_BASE;   end
      OPC_AUIPC:  begin itype = TYPE_U; head = HEAD_ALT;    end
      OPC_JAL:    begin itype = TYPE_J; head = HEAD_BASE;   end
      OPC_BRANCH: begin itype = TYPE_B; head = HEAD_BASE;   end
      default:    begin itype = TYPE_NONE; head = HEAD_NONE; end
    endcase
  end

  always_comb begin
    imm = 32'd0;
    case (itype)
      TYPE_I:  imm = {{21{instr[31]}}, instr[30:20]};
      TYPE_S:  imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      TYPE_B:  imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      TYPE_U:  imm = {instr[31:12], 12'd0};
      TYPE_J:  imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  assign op      = make_op(itype, head, {instr[30], instr[14:12]});
  assign rs1     = REG_ADDR_WIDTH'(instr[19:15]);
  assign rs2     = REG_ADDR_WIDTH'(instr[24:20]);
  assign rd      = REG_ADDR_WIDTH'(instr[11:7]);
  assign illegal = (itype == TYPE_NONE);

endmodule

// File: rtl/issue_queue.sv
// Issue queue: DEPTH-entry FIFO of {instr, npc}; decodes the head and dispatches one instruction per cycle
// as a registered pulse to RS or SLB (push-to-valid two edges); a stalled target holds the head, unknown opcodes are dropped.
module issue_queue import issue_queue_pkg::*; #(
  parameter int DEPTH          = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic         clk_in,
  input  logic         rst_in,
  issue_queue_if.slave iq
);

  iq_entry_t                 mem_q [DEPTH];
  iq_entry_t                 mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]       count_q, count_d;
  logic                      rs_valid_q, rs_valid_d;
  logic                      slb_valid_q, slb_valid_d;
  logic                      illegal_q, illegal_d;
  logic [OP_WIDTH-1:0]       op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [31:0]               imm_q, imm_d;
  logic [31:0]               npc_q, npc_d;

  iq_entry_t                 head;
  logic [OP_WIDTH-1:0]       dec_op;
  logic [REG_ADDR_WIDTH-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [31:0]               dec_imm;
  logic                      dec_to_slb, dec_illegal;
  logic                      empty, push, tgt_ready, pop_legal, pop_illegal, pop;

  assign head = mem_q[rd_ptr_q];

  issue_queue_decode #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_decode (
    .instr   (head.instr),
    .op      (dec_op),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .imm     (dec_imm),
    .to_slb  (dec_to_slb),
    .illegal (dec_illegal)
  );

  // in_ready looks only at the current count, so a full queue never accepts even while popping.
  assign empty       = (count_q == '0);
  assign iq.in_ready = (count_q != (ADDR_WIDTH+1)'(DEPTH));
  assign push        = iq.in_valid && iq.in_ready;
  assign tgt_ready   = dec_to_slb ? iq.slb_ready_in : iq.rs_ready_in;
  assign pop_illegal = !empty && dec_illegal;
  assign pop_legal   = !empty && !dec_illegal && tgt_ready;
  assign pop         = pop_illegal || pop_legal;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rs_valid_d  = 1'b0;
    slb_valid_d = 1'b0;
    illegal_d   = 1'b0;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    npc_d       = npc_q;
    if (iq.flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (iq.rdy_in) begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: iq.in_instr, npc: iq.in_npc};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d   = count_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      illegal_d = pop_illegal;
      if (pop_legal) begin
        rs_valid_d  = !dec_to_slb;
        slb_valid_d = dec_to_slb;
        op_d        = dec_op;
        rs1_d       = dec_rs1;
        rs2_d       = dec_rs2;
        rd_d        = dec_rd;
        imm_d       = dec_imm;
        npc_d       = head.npc;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rs_valid_q  <= 1'b0;
      slb_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      npc_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rs_valid_q  <= rs_valid_d;
      slb_valid_q <= slb_valid_d;
      illegal_q   <= illegal_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      npc_q       <= npc_d;
    end
  end

  // Storage needs no reset: entries are only read below count_q.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign iq.rs_valid    = rs_valid_q;
  assign iq.slb_valid   = slb_valid_q;
  assign iq.illegal_out = illegal_q;
  assign iq.out_op      = op_q;
  assign iq.out_rs1     = rs1_q;
  assign iq.out_rs2     = rs2_q;
  assign iq.out_rd      = rd_q;
  assign iq.out_imm     = imm_q;
  assign iq.out_npc     = npc_q;
  assign iq.count_out   = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios and random traffic against a queue-based reference model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int RW    = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  issue_queue_if #(.ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) bus ();

  issue_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .iq     (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } ent_t;

  typedef struct {
    bit          ok;
    bit          slb;
    logic [9:0]  op;
    logic [31:0] imm;
  } ref_t;

  ent_t        mq[$];
  logic        e_rs, e_slb, e_ill;
  logic [9:0]  e_op;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [31:0] e_imm, e_npc;
  logic [6:0]  opc_tab [12] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100111, 7'b0001111, 7'b1110011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b1100011, 7'b1111111};

  // Immediates built by placing the field at the top of a word and shifting it down arithmetically.
  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    logic signed [31:0] s;
    int ty, hd;
    byte fmt;
    r = '{default: 0};
    ty = 0; hd = 0; fmt = "-";
    case (w[6:0])
      7'b0110011: begin ty = 1; hd = 1; fmt = "R"; end
      7'b0100011: begin ty = 3; hd = 1; fmt = "S"; r.slb = 1; end
      7'b0000011: begin ty = 2; hd = 1; fmt = "I"; r.slb = 1; end
      7'b0010011: begin ty = 2; hd = 2; fmt = "I"; end
      7'b1100111: begin ty = 2; hd = 3; fmt = "I"; end
      7'b0001111: begin ty = 2; hd = 4; fmt = "I"; end
      7'b1110011: begin ty = 2; hd = 5; fmt = "I"; end
      7'b0110111: begin ty = 5; hd = 1; fmt = "U"; end
      7'b0010111: begin ty = 5; hd = 2; fmt = "U"; end
      7'b1101111: begin ty = 6; hd = 1; fmt = "J"; end
      7'b1100011: begin ty = 4; hd = 1; fmt = "B"; end
      default:    begin ty = 0; hd = 0; fmt = "-"; end
    endcase
    s = 0;
    case (fmt)
      "I": s = $signed({w[31:20], 20'd0}) >>> 20;
      "S": s = $signed({w[31:25], w[11:7], 20'd0}) >>> 20;
      "B": s = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'd0}) >>> 19;
      "J": s = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'd0}) >>> 11;
      "U": s = $signed(w & 32'hFFFF_F000);
      default: s = 0;
    endcase
    r.imm = s;
    r.ok  = (ty != 0);
    r.op  = {3'(ty), 3'(hd), w[30], w[14:12]};
    if (!r.ok) r.slb = 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Predict the effect of the coming edge from the current inputs, take the edge, compare.
  task automatic tick();
    ent_t h;
    ref_t d;
    bit   pushed;
    if (!rst_n) begin
      mq.delete();
      e_rs = 0; e_slb = 0; e_ill = 0;
      e_op = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_imm = 0; e_npc = 0;
    end else if (bus.flush_in) begin
      mq.delete();
      e_rs = 0; e_slb = 0; e_ill = 0;
    end else if (!bus.rdy_in) begin
      e_rs = 0; e_slb = 0; e_ill = 0;
    end else begin
      e_rs = 0; e_slb = 0; e_ill = 0;
      pushed = bus.in_valid && (mq.size() < DEPTH);
      if (mq.size() != 0) begin
        h = mq[0];
        d = ref_decode(h.instr);
        if (!d.ok) begin
          e_ill = 1;
          void'(mq.pop_front());
        end else if (d.slb ? bus.slb_ready_in : bus.rs_ready_in) begin
          void'(mq.pop_front());
          e_slb = d.slb;
          e_rs  = !d.slb;
          e_op  = d.op;
          e_rs1 = h.instr[19:15];
          e_rs2 = h.instr[24:20];
          e_rd  = h.instr[11:7];
          e_imm = d.imm;
          e_npc = h.npc;
        end
      end
      if (pushed) mq.push_back('{bus.in_instr, bus.in_npc});
    end
    @(posedge clk);
    #1;
    chk("rs_valid",    32'(bus.rs_valid),    32'(e_rs));
    chk("slb_valid",   32'(bus.slb_valid),   32'(e_slb));
    chk("illegal_out", 32'(bus.illegal_out), 32'(e_ill));
    chk("count_out",   32'(bus.count_out),   32'(mq.size()));
    chk("in_ready",    32'(bus.in_ready),    32'(mq.size() != DEPTH));
    chk("out_op",      32'(bus.out_op),      32'(e_op));
    chk("out_rs1",     32'(bus.out_rs1),     32'(e_rs1));
    chk("out_rs2",     32'(bus.out_rs2),     32'(e_rs2));
    chk("out_rd",      32'(bus.out_rd),      32'(e_rd));
    chk("out_imm",     bus.out_imm,          e_imm);
    chk("out_npc",     bus.out_npc,          e_npc);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] npc);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_npc   = npc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w      = $urandom;
    w[6:0] = opc_tab[$urandom_range(0, 11)];
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.rdy_in = 1'b1;
    bus.flush_in = 1'b0;
    bus.rs_ready_in = 1'b1;
    bus.slb_ready_in = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single addi: valid exactly two edges after the push, for one cycle.
    drive(1'b1, 32'h0050_0093, 32'h4);
    tick();
    chk("t1_no_early_valid", 32'(bus.rs_valid), 32'd0);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("t1_rs_valid", 32'(bus.rs_valid), 32'd1);
    chk("t1_op", 32'(bus.out_op), 32'(10'b010_010_0000));
    chk("t1_rd", 32'(bus.out_rd), 32'd1);
    chk("t1_imm", bus.out_imm, 32'd5);
    chk("t1_npc", bus.out_npc, 32'h4);
    tick();
    chk("t1_pulse_end", 32'(bus.rs_valid), 32'd0);

    // Store held by an SLB stall; instr[30] is set in this encoding so sub is 4'b1010.
    bus.slb_ready_in = 1'b0;
    drive(1'b1, 32'hFE20_AE23, 32'h8);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    bus.slb_ready_in = 1'b1;
    tick();
    chk("t2_slb_valid", 32'(bus.slb_valid), 32'd1);
    chk("t2_op", 32'(bus.out_op), 32'(10'b011_001_1010));
    chk("t2_imm", bus.out_imm, 32'hFFFF_FFFC);

    // Fill past DEPTH with RS stalled, then drain in order across the pointer wrap.
    bus.rs_ready_in = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      drive(1'b1, 32'h0000_0093 | (32'(i) << 20) | (32'(i) << 7), 32'h100 + 32'(4 * i));
      tick();
    end
    chk("t3_full_count", 32'(bus.count_out), 32'(DEPTH));
    chk("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 32'd0, 32'd0);
    bus.rs_ready_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("t3_drain_npc", bus.out_npc, 32'h100 + 32'(4 * i));
    end
    tick();
    chk("t3_no_extra", 32'(bus.rs_valid), 32'd0);

    // Flush with a simultaneous push: everything, including the push, is lost.
    bus.rs_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0010_0113, 32'h200 + 32'(4 * i));
      tick();
    end
    bus.flush_in = 1'b1;
    drive(1'b1, 32'h0020_0193, 32'h300);
    tick();
    chk("t4_flush_count", 32'(bus.count_out), 32'd0);
    bus.flush_in = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    bus.rs_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Illegal head dropped with a pulse, lui behind it dispatches.
    drive(1'b1, 32'hFFFF_FFFF, 32'h400);
    tick();
    drive(1'b1, 32'h1234_52B7, 32'h404);
    tick();
    chk("t5_illegal", 32'(bus.illegal_out), 32'd1);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("t5_rs_valid", 32'(bus.rs_valid), 32'd1);
    chk("t5_type", 32'(bus.out_op[9:7]), 32'd5);
    chk("t5_imm", bus.out_imm, 32'h1234_5000);
    chk("t5_rd", 32'(bus.out_rd), 32'd5);

    // Streaming with a two-cycle freeze in the middle.
    for (int i = 0; i < 8; i++) begin
      bus.rdy_in = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      drive(1'b1, rand_instr(), 32'h500 + 32'(4 * i));
      tick();
    end
    bus.rdy_in = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst_n            = ($urandom_range(0, 249) != 0);
      bus.flush_in     = ($urandom_range(0, 39) == 0);
      bus.rdy_in       = ($urandom_range(0, 9) != 0);
      bus.rs_ready_in  = ($urandom_range(0, 9) < 7);
      bus.slb_ready_in = ($urandom_range(0, 9) < 6);
      drive(1'($urandom_range(0, 2) != 0), rand_instr(), $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
